// File: rtl/id_issue_ctrl_pkg.sv
// Shared defaults and types for the decode-stage issue controller.
package id_issue_ctrl_pkg;

  localparam int unsigned WB_DIST_DEF    = 3;
  localparam int unsigned MUL_CYCLES_DEF = 2;
  localparam int unsigned REG_IDX_W      = 5;
  localparam int unsigned NUM_REGS       = 32;

  typedef enum logic {
    MUL_IDLE = 1'b0,
    MUL_BUSY = 1'b1
  } mul_state_e;

  // Countdown width able to hold the longest producer latency (multiply).
  function automatic int unsigned sb_width(input int unsigned wb_dist,
                                           input int unsigned mul_cycles);
    return $clog2(wb_dist + mul_cycles + 1);
  endfunction

endpackage

// File: rtl/id_scoreboard.sv
// Per-register countdown scoreboard: nonzero entry means the value is not yet
// readable from the register file. Entry 0 is permanently idle.
module id_scoreboard
  import id_issue_ctrl_pkg::*;
#(
  parameter int unsigned SB_W = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_set,
  input  logic [REG_IDX_W-1:0] i_set_idx,
  input  logic [SB_W-1:0]      i_set_val,
  input  logic [REG_IDX_W-1:0] i_rd_a_idx,
  input  logic [REG_IDX_W-1:0] i_rd_b_idx,
  output logic                 o_rd_a_busy_c,
  output logic                 o_rd_b_busy_c
);

  logic [SB_W-1:0] r_sb [NUM_REGS];

  // A set on the same entry overrides that cycle's decrement.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_sb[i] <= '0;
      end
    end else begin
      r_sb[0] <= '0;
      for (int i = 1; i < NUM_REGS; i++) begin
        if (i_set && (i_set_idx == REG_IDX_W'(i))) begin
          r_sb[i] <= i_set_val;
        end else if (r_sb[i] != '0) begin
          r_sb[i] <= r_sb[i] - SB_W'(1);
        end
      end
    end
  end

  assign o_rd_a_busy_c = (r_sb[i_rd_a_idx] != '0);
  assign o_rd_b_busy_c = (r_sb[i_rd_b_idx] != '0);

endmodule

// File: rtl/id_issue_ctrl.sv
// Decode-stage issue controller: scoreboard data hazards, multi-cycle multiply
// structural hazard, branch flush priority and a saturating stall counter.
module id_issue_ctrl
  import id_issue_ctrl_pkg::*;
#(
  parameter int unsigned WB_DIST    = WB_DIST_DEF,
  parameter int unsigned MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 if_id_valid_inst,
  input  logic                 id_illegal,
  input  logic [REG_IDX_W-1:0] ra_idx,
  input  logic [REG_IDX_W-1:0] rb_idx,
  input  logic                 uses_ra,
  input  logic                 uses_rb,
  input  logic [REG_IDX_W-1:0] dest_idx,
  input  logic                 reg_wr,
  input  logic                 is_mul,
  input  logic                 ex_take_branch,
  output logic                 pc_enable,
  output logic                 if_id_enable,
  output logic                 if_id_flush,
  output logic                 id_ex_bubble,
  output logic                 issue_valid,
  output logic                 mul_busy,
  output logic [CNT_W-1:0]     stall_count
);

  localparam int unsigned SB_W  = sb_width(WB_DIST, MUL_CYCLES);
  localparam int unsigned MUL_W = $clog2(MUL_CYCLES + 1);

  localparam logic [SB_W-1:0]  SB_ALU_VAL = SB_W'(WB_DIST);
  localparam logic [SB_W-1:0]  SB_MUL_VAL = SB_W'(WB_DIST + MUL_CYCLES - 1);
  localparam logic [MUL_W-1:0] MUL_LOAD   = MUL_W'(MUL_CYCLES - 1);

  mul_state_e        r_mul_state;
  mul_state_e        w_mul_state_nxt;
  logic [MUL_W-1:0]  r_mul_cnt;
  logic [MUL_W-1:0]  w_mul_cnt_nxt;
  logic [CNT_W-1:0]  r_stall_cnt;

  logic              w_ra_busy;
  logic              w_rb_busy;
  logic              w_data_haz;
  logic              w_struct_haz;
  logic              w_stall;
  logic              w_sb_set;
  logic [SB_W-1:0]   w_sb_val;

  id_scoreboard #(
    .SB_W (SB_W)
  ) u_sb (
    .clk           (clk),
    .rst           (rst),
    .i_set         (w_sb_set),
    .i_set_idx     (dest_idx),
    .i_set_val     (w_sb_val),
    .i_rd_a_idx    (ra_idx),
    .i_rd_b_idx    (rb_idx),
    .o_rd_a_busy_c (w_ra_busy),
    .o_rd_b_busy_c (w_rb_busy)
  );

  assign w_data_haz   = (uses_ra && (ra_idx != '0) && w_ra_busy) ||
                        (uses_rb && (rb_idx != '0) && w_rb_busy);
  assign w_struct_haz = mul_busy;
  assign mul_busy     = (r_mul_state == MUL_BUSY);
  assign stall_count  = r_stall_cnt;

  assign w_sb_set = issue_valid && reg_wr && (dest_idx != '0);
  assign w_sb_val = is_mul ? SB_MUL_VAL : SB_ALU_VAL;

  // Pipeline control, highest priority first: branch flush, hazard stall,
  // illegal bubble, normal issue, empty slot.
  always_comb begin
    pc_enable    = 1'b1;
    if_id_enable = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    issue_valid  = 1'b0;
    w_stall      = 1'b0;
    if (ex_take_branch) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (if_id_valid_inst && (w_data_haz || w_struct_haz)) begin
      pc_enable    = 1'b0;
      if_id_enable = 1'b0;
      id_ex_bubble = 1'b1;
      w_stall      = 1'b1;
    end else if (if_id_valid_inst && id_illegal) begin
      id_ex_bubble = 1'b1;
    end else if (if_id_valid_inst) begin
      issue_valid  = 1'b1;
    end else begin
      id_ex_bubble = 1'b1;
    end
  end

  // Multiply occupancy: busy for the MUL_CYCLES-1 cycles after issue.
  always_comb begin
    w_mul_state_nxt = r_mul_state;
    w_mul_cnt_nxt   = r_mul_cnt;
    case (r_mul_state)
      MUL_IDLE: begin
        if (issue_valid && is_mul && (MUL_CYCLES > 1)) begin
          w_mul_state_nxt = MUL_BUSY;
          w_mul_cnt_nxt   = MUL_LOAD;
        end
      end
      MUL_BUSY: begin
        if (r_mul_cnt == MUL_W'(1)) begin
          w_mul_state_nxt = MUL_IDLE;
          w_mul_cnt_nxt   = '0;
        end else begin
          w_mul_cnt_nxt   = r_mul_cnt - MUL_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mul_state <= MUL_IDLE;
      r_mul_cnt   <= '0;
    end else begin
      r_mul_state <= w_mul_state_nxt;
      r_mul_cnt   <= w_mul_cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_id_issue_ctrl.sv
// Bench for id_issue_ctrl: directed scenarios then random traffic, checked
// against a ready-time model of register and multiplier availability.
module tb_id_issue_ctrl;
  import id_issue_ctrl_pkg::*;

  localparam int unsigned WB = 3;
  localparam int unsigned MC = 2;
  localparam int unsigned CW = 32;

  logic          clk;
  logic          rst;
  logic          if_id_valid_inst;
  logic          id_illegal;
  logic [4:0]    ra_idx;
  logic [4:0]    rb_idx;
  logic          uses_ra;
  logic          uses_rb;
  logic [4:0]    dest_idx;
  logic          reg_wr;
  logic          is_mul;
  logic          ex_take_branch;
  logic          pc_enable;
  logic          if_id_enable;
  logic          if_id_flush;
  logic          id_ex_bubble;
  logic          issue_valid;
  logic          mul_busy;
  logic [CW-1:0] stall_count;

  id_issue_ctrl #(
    .WB_DIST    (WB),
    .MUL_CYCLES (MC),
    .CNT_W      (CW)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .if_id_valid_inst (if_id_valid_inst),
    .id_illegal       (id_illegal),
    .ra_idx           (ra_idx),
    .rb_idx           (rb_idx),
    .uses_ra          (uses_ra),
    .uses_rb          (uses_rb),
    .dest_idx         (dest_idx),
    .reg_wr           (reg_wr),
    .is_mul           (is_mul),
    .ex_take_branch   (ex_take_branch),
    .pc_enable        (pc_enable),
    .if_id_enable     (if_id_enable),
    .if_id_flush      (if_id_flush),
    .id_ex_bubble     (id_ex_bubble),
    .issue_valid      (issue_valid),
    .mul_busy         (mul_busy),
    .stall_count      (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;

  // Model: cycle index at which each register becomes readable, and the
  // first cycle at which the multiplier is free again.
  int          cyc;
  int          ready_at [32];
  int          mul_free_at;
  int unsigned sc_m;

  logic [31:0] obs_issue;
  logic [31:0] obs_stall;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic v, input logic ill,
                      input logic [4:0] ra, input logic ua,
                      input logic [4:0] rb, input logic ub,
                      input logic [4:0] d, input logic wr, input logic mul,
                      input logic br, input logic chk);
    logic dh, sh, e_pc, e_ifid, e_fl, e_bub, e_iss, e_stall;
    rst = r; if_id_valid_inst = v; id_illegal = ill;
    ra_idx = ra; uses_ra = ua; rb_idx = rb; uses_rb = ub;
    dest_idx = d; reg_wr = wr; is_mul = mul; ex_take_branch = br;
    @(negedge clk);
    dh = (ua && ra != 0 && ready_at[ra] > cyc) || (ub && rb != 0 && ready_at[rb] > cyc);
    sh = (cyc < mul_free_at);
    e_pc = 1; e_ifid = 1; e_fl = 0; e_bub = 0; e_iss = 0; e_stall = 0;
    if (br) begin
      e_fl = 1; e_bub = 1;
    end else if (v && (dh || sh)) begin
      e_pc = 0; e_ifid = 0; e_bub = 1; e_stall = 1;
    end else if (v && ill) begin
      e_bub = 1;
    end else if (v) begin
      e_iss = 1;
    end else begin
      e_bub = 1;
    end
    if (chk) begin
      check("pc_enable", 32'(pc_enable), 32'(e_pc));
      check("if_id_enable", 32'(if_id_enable), 32'(e_ifid));
      check("if_id_flush", 32'(if_id_flush), 32'(e_fl));
      check("id_ex_bubble", 32'(id_ex_bubble), 32'(e_bub));
      check("issue_valid", 32'(issue_valid), 32'(e_iss));
      check("mul_busy", 32'(mul_busy), 32'(sh));
      check("stall_count", stall_count, sc_m);
    end
    obs_issue = 32'(issue_valid);
    obs_stall = stall_count;
    @(posedge clk);
    if (r) begin
      foreach (ready_at[i]) ready_at[i] = 0;
      mul_free_at = 0;
      sc_m = 0;
    end else begin
      if (e_stall && sc_m != 32'hFFFF_FFFF) sc_m++;
      if (e_iss && wr && d != 0)
        ready_at[d] = cyc + int'(WB) + (mul ? int'(MC) - 1 : 0) + 1;
      if (e_iss && mul && MC > 1)
        mul_free_at = cyc + int'(MC);
    end
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  initial begin
    int unsigned s0;
    checks = 0; failures = 0; cyc = 0; mul_free_at = 0; sc_m = 0;
    foreach (ready_at[i]) ready_at[i] = 0;

    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(1);
    check("reset_stall_count", obs_stall, 0);

    // Back-to-back producer/consumer: three stall cycles then issue.
    step(0, 1, 0, 1, 1, 2, 1, 5, 1, 0, 0, 1);
    for (int k = 0; k < 4; k++) step(0, 1, 0, 5, 1, 1, 1, 6, 1, 0, 0, 1);
    check("raw_issue_after_3", obs_issue, 1);
    check("raw_stall_count", obs_stall, 3);
    idle(4);

    // Multiply then an independent add: one structural stall.
    step(0, 1, 0, 1, 1, 2, 1, 7, 1, 1, 0, 1);
    step(0, 1, 0, 1, 1, 2, 1, 8, 1, 0, 0, 1);
    check("mul_struct_stall", obs_issue, 0);
    step(0, 1, 0, 1, 1, 2, 1, 8, 1, 0, 0, 1);
    check("mul_struct_issue", obs_issue, 1);
    idle(5);

    // Multiply then a dependent add: WB_DIST+1 stalls.
    step(0, 1, 0, 1, 1, 2, 1, 7, 1, 1, 0, 1);
    s0 = sc_m;
    for (int k = 0; k < 5; k++) step(0, 1, 0, 7, 1, 1, 0, 9, 1, 0, 0, 1);
    check("mul_dep_issue", obs_issue, 1);
    check("mul_dep_stalls", obs_stall - s0, 4);
    idle(5);

    // Branch during a hazard stall flushes instead of stalling.
    step(0, 1, 0, 0, 0, 0, 0, 5, 1, 0, 0, 1);
    step(0, 1, 0, 5, 1, 0, 0, 6, 1, 0, 1, 1);
    check("branch_no_issue", obs_issue, 0);
    idle(4);

    // x0 writes/reads and unused source fields never hazard.
    step(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
    step(0, 1, 0, 0, 1, 0, 1, 11, 1, 0, 0, 1);
    check("x0_no_stall", obs_issue, 1);
    step(0, 1, 0, 0, 0, 0, 0, 10, 1, 0, 0, 1);
    step(0, 1, 0, 10, 0, 10, 0, 12, 1, 0, 0, 1);
    check("unused_src_no_stall", obs_issue, 1);
    idle(4);

    // Reset while the multiplier is busy clears everything.
    step(0, 1, 0, 0, 0, 0, 0, 5, 1, 1, 0, 1);
    step(1, 1, 0, 5, 1, 0, 0, 6, 1, 0, 0, 1);
    step(0, 1, 0, 5, 1, 0, 0, 6, 1, 0, 0, 1);
    check("post_rst_issue", obs_issue, 1);
    check("post_rst_stall", obs_stall, 0);
    idle(4);

    // Illegal instruction leaves no scoreboard reservation.
    step(0, 1, 1, 0, 0, 0, 0, 4, 1, 0, 0, 1);
    check("illegal_no_issue", obs_issue, 0);
    step(0, 1, 0, 4, 1, 0, 0, 3, 1, 0, 0, 1);
    check("illegal_reader_issue", obs_issue, 1);
    idle(4);

    // Random traffic over a small register window to provoke hazards.
    for (int n = 0; n < 800; n++) begin
      step($urandom_range(99) < 2,
           $urandom_range(99) < 80,
           $urandom_range(99) < 5,
           5'($urandom_range(7)), 1'($urandom_range(1)),
           5'($urandom_range(7)), 1'($urandom_range(1)),
           5'($urandom_range(7)), $urandom_range(99) < 85,
           $urandom_range(99) < 20,
           $urandom_range(99) < 10, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
